wb_prefetch_buffer: RTL and testbench
=====================================

# wb_prefetch_buffer

Instruction prefetch unit that is a pipelined Wishbone read master on instruction port 0 of the dual-port memory. It streams sequential word fetches into a small FIFO and presents them to the core fetch stage with a valid/ready handshake. On a branch redirect it flushes its contents and discards stale responses. Bus errors are forwarded to the core tagged to the faulting instruction.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  flush and restart fetching at redirect_pc_i.
- redirect_pc_i  in  32  new fetch address; bits [1:0] forced to 0.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  32  address of head word.
- instr_err_o  out  1  head entry came from wb_err_i.
- instr_ready_i  in  1  core consumes the head this cycle.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write enable (wb_we_o is constant 0).
- wb_adr_o  out  32  byte address, word-aligned.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_stall_i  in  1 each  Wishbone ack, error, stall.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - outstanding: requests accepted but not yet acked/erred. Width $clog2(DEPTH)+1.
  - discard: stale responses still to drop. Same width as outstanding.
  - FIFO of {err, pc, data}.
- Credit rule: a request may issue only when FIFO count + outstanding < DEPTH. This rule guarantees the FIFO can never overflow.
- wb_stb_o = (state==FETCH) && credit. It is driven from registered state only and never depends combinationally on redirect_i.
- A request is accepted when wb_stb_o && !wb_stall_i. On acceptance: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
- While stalled, wb_adr_o and wb_stb_o hold their values.
- wb_cyc_o = wb_stb_o || outstanding != 0.
- Responses (ack or err):
  - outstanding decrements.
  - If discard != 0: discard decrements and nothing is pushed.
  - Otherwise push {wb_err_i, issue pc, wb_dat_i}. The issue pc is tracked by a response-pc counter that advances by 4 per non-discarded response.
- Pop occurs when instr_valid_o && instr_ready_i.
- States:
  - FETCH: normal issue. A pushed err entry → HALT.
  - FLUSH: no issue. → FETCH when discard reaches 0, including the same-cycle decrement.
  - HALT: no issue; waits for redirect.
- redirect_i, from any state:
  - Clear the FIFO.
  - Set fetch_pc and the response pc to redirect_pc_i & ~3.
  - Set discard = outstanding + (request accepted this cycle) − (response this cycle).
  - Next state is FLUSH if that value is nonzero, otherwise FETCH.
- Simultaneous events:
  - Redirect beats pop; the pop is ignored.
  - A response in the redirect cycle is stale and dropped.
  - A request accepted in the redirect cycle counts as stale.
  - Redirect during FLUSH recomputes discard by the same formula.
- Reset values:
  - State FETCH; fetch_pc = response pc = RESET_PC.
  - outstanding = discard = 0; FIFO empty.
  - All outputs 0 except wb_sel_o = 4'hF.
  - wb_adr_o = RESET_PC & ~3.

## Timing
- With memory ack latency 1 and stall 0, steady-state throughput is one instruction per cycle when instr_ready_i is held high.
- Deassertion of wb_rst_n_i before edge E0: wb_stb_o is high in the cycle after E0. Ack follows one cycle later. instr_valid_o rises the cycle after the ack.
- Redirect-to-valid latency is 3 cycles when outstanding is 0; longer when stale responses must drain.
- FIFO outputs are registered, so a push becomes visible the cycle after the ack.
- Push and pop in the same cycle leave the count unchanged.
- Reset assertion mid-burst immediately clears all state asynchronously. Any later responses from the memory are ignored because outstanding is 0 (ack with outstanding 0 is a protocol violation; it is dropped).

## Structure
- Package wb_prefetch_pkg:
  - state enum {FETCH, FLUSH, HALT}.
  - Entry struct {err, pc[31:0], data[31:0]}.
- Sub-module prefetch_fifo: synchronous FIFO, DEPTH entries, push/pop/clear, count output, registered head.

## Test plan
- Reset with RESET_PC=0x100 and ready=1, memory holding word n = 0x1000+n → instr_pc_o sequence 0x100, 0x104, 0x108…, one per cycle, with instr_o matching memory.
- ready=0 for 10 cycles (DEPTH=4) → exactly 4 requests issued, then wb_stb_o low. Raising ready resumes issue with no lost or duplicated words.
- Redirect to 0x200 with 2 outstanding → next 2 acks are dropped. First valid output has pc 0x200, and no pre-redirect word reaches the core.
- Redirect, pop and ack in the same cycle → FIFO empty next cycle, the ack is discarded, fetch restarts at the new pc.
- wb_stall_i high for 3 cycles → wb_adr_o stable, no pc advance, data order preserved.
- wb_err_i on the fetch of 0x108 → entry with instr_err_o=1, pc 0x108 delivered, issue stops (HALT). A redirect to 0x0 resumes fetching.

Source files
------------

// File: rtl/wb_prefetch_pkg.sv
// Shared types for the instruction prefetch buffer.
// Provides the FSM state enum, FIFO entry layout and word alignment.
package wb_prefetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/wb_prefetch_buffer_fifo.sv
// Synchronous FIFO of fetched entries with clear and occupancy count.
// Ports: clk/rst_n, clear, push+push_entry, pop, head (registered), count.
module prefetch_fifo
    import wb_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_prefetch_buffer.sv
// Pipelined Wishbone instruction prefetcher feeding a valid/ready FIFO.
// Ports: wb_clk_i/wb_rst_n_i, redirect, instr_* to core, wb_* master.
module wb_prefetch_buffer
    import wb_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    state_t         state_q;
    state_t         state_n;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    fetch_pc_n;
    logic [31:0]    rsp_pc_q;
    logic [31:0]    rsp_pc_n;
    logic [CW-1:0]  out_q;
    logic [CW-1:0]  out_n;
    logic [CW-1:0]  disc_q;
    logic [CW-1:0]  disc_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic           stb_q;
    logic           stb_n;
    logic           req;
    logic           rsp;
    logic           push;
    logic           pop;
    entry_t         head;
    entry_t         push_entry;

    // Responses with nothing outstanding are protocol violations.
    assign req  = stb_q && !wb_stall_i;
    assign rsp  = (wb_ack_i || wb_err_i) && (out_q != '0);
    assign push = rsp && (disc_q == '0) && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign push_entry = '{err: wb_err_i, pc: rsp_pc_q, data: wb_dat_i};

    always_comb begin
        out_n      = out_q + CW'(req) - CW'(rsp);
        cnt_n      = cnt + CW'(push) - CW'(pop);
        state_n    = state_q;
        disc_n     = disc_q;
        fetch_pc_n = fetch_pc_q;
        rsp_pc_n   = rsp_pc_q;
        if (req) begin
            fetch_pc_n = fetch_pc_q + 32'd4;
        end
        if (push) begin
            rsp_pc_n = rsp_pc_q + 32'd4;
        end
        if (rsp && (disc_q != '0)) begin
            disc_n = disc_q - 1'b1;
        end
        unique case (state_q)
            FETCH: if (push && wb_err_i) state_n = HALT;
            FLUSH: if (disc_n == '0) state_n = FETCH;
            HALT:  state_n = HALT;
            default: state_n = FETCH;
        endcase
        // Everything in flight at redirect time is stale.
        if (redirect_i) begin
            cnt_n      = '0;
            fetch_pc_n = word_align(redirect_pc_i);
            rsp_pc_n   = word_align(redirect_pc_i);
            disc_n     = out_n;
            state_n    = (out_n != '0) ? FLUSH : FETCH;
        end
        // Credit covers FIFO slots plus in-flight requests, so a
        // stalled strobe always keeps its credit.
        stb_n = (state_n == FETCH) &&
                (({1'b0, cnt_n} + {1'b0, out_n}) < LIMIT);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= word_align(RESET_PC);
            rsp_pc_q   <= word_align(RESET_PC);
            out_q      <= '0;
            disc_q     <= '0;
            stb_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            rsp_pc_q   <= rsp_pc_n;
            out_q      <= out_n;
            disc_q     <= disc_n;
            stb_q      <= stb_n;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .clear      (redirect_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (cnt)
    );

    assign instr_valid_o = (cnt != '0);
    assign instr_o       = head.data;
    assign instr_pc_o    = head.pc;
    assign instr_err_o   = head.err;

    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q || (out_q != '0);
    assign wb_we_o  = 1'b0;
    assign wb_adr_o = fetch_pc_q;
    assign wb_sel_o = 4'hF;

endmodule

// File: tb/tb_wb_prefetch_buffer.sv
// Directed bench for wb_prefetch_buffer with a pipelined memory model.
// Memory word at byte address a holds 0x1000 + (a >> 2).
module tb_wb_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ierr;
    logic        ready;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        stall;

    logic        resp_en;
    logic [31:0] err_addr;
    logic [31:0] pend [$];
    logic [31:0] ra;
    int          acc_cnt;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_pc;
    logic        seen_err;
    int          base;
    logic [31:0] hold_adr;
    logic [31:0] target;

    wb_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .instr_pc_o    (ipc),
        .instr_err_o   (ierr),
        .instr_ready_i (ready),
        .wb_cyc_o      (cyc),
        .wb_stb_o      (stb),
        .wb_we_o       (we),
        .wb_adr_o      (adr),
        .wb_sel_o      (sel),
        .wb_dat_i      (dat),
        .wb_ack_i      (ack),
        .wb_err_i      (err),
        .wb_stall_i    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Pipelined slave: accepted addresses queue up and are answered
    // one per cycle, in order, the cycle after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            ack <= 1'b0;
            err <= 1'b0;
            dat <= '0;
            acc_cnt = 0;
        end else begin
            if (cyc && stb && !stall) begin
                pend.push_back(adr);
                acc_cnt = acc_cnt + 1;
            end
            ack <= 1'b0;
            err <= 1'b0;
            if (resp_en && pend.size() > 0) begin
                ra = pend.pop_front();
                if (ra == err_addr) err <= 1'b1;
                else ack <= 1'b1;
                dat <= memword(ra);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Score any word the core takes this cycle, then advance one clock.
    task automatic tick();
        if (valid && ready && !redirect) begin
            chk("pc", ipc, exp_pc);
            chk("data", instr, memword(exp_pc));
            chk("ierr", {31'b0, ierr}, {31'b0, exp_pc == err_addr});
            if (ierr) seen_err = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input logic [31:0] tgt, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_pc == tgt) break;
            tick();
        end
        chk("stream_end", exp_pc, tgt);
    endtask

    task automatic do_reset(input logic rdy, input logic rsp);
        rst_n    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        ready    = rdy;
        resp_en  = rsp;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_cyc", {31'b0, cyc}, 32'd0);
        chk("rst_stb", {31'b0, stb}, 32'd0);
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_sel", {28'b0, sel}, 32'hF);
        chk("rst_adr", adr, 32'h100);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", ipc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h100;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        err_addr    = 32'hFFFF_FFFF;
        exp_pc      = 32'h100;
        seen_err    = 1'b0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ready       = 1'b1;
        stall       = 1'b0;
        resp_en     = 1'b1;
        @(negedge clk);

        // Reset, then one word per cycle with ready held high.
        do_reset(1'b1, 1'b1);
        tick();
        chk("t1_stb", {31'b0, stb}, 32'd1);
        chk("t1_adr", adr, 32'h100);
        tick();
        chk("t1_valid_lo", {31'b0, valid}, 32'd0);
        chk("t1_ack", {31'b0, ack}, 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_valid", {31'b0, valid}, 32'd1);
            tick();
        end
        chk("t1_count", exp_pc, 32'h118);

        // Back-pressure: only DEPTH requests may be issued.
        do_reset(1'b0, 1'b1);
        base = acc_cnt;
        repeat (10) tick();
        chk("t2_reqs", acc_cnt - base, 32'd4);
        chk("t2_stb", {31'b0, stb}, 32'd0);
        chk("t2_valid", {31'b0, valid}, 32'd1);
        chk("t2_head", ipc, 32'h100);
        ready = 1'b1;
        run_until(32'h130, 20);

        // Redirect with two responses still outstanding.
        do_reset(1'b1, 1'b0);
        base = acc_cnt;
        tick();
        tick();
        tick();
        chk("t3_out", acc_cnt - base, 32'd2);
        chk("t3_adr", adr, 32'h108);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        resp_en  = 1'b1;
        chk("t3_stb", {31'b0, stb}, 32'd0);
        chk("t3_valid", {31'b0, valid}, 32'd0);
        chk("t3_adr2", adr, 32'h200);
        exp_pc = 32'h200;
        run_until(32'h210, 30);

        // Redirect, pop and ack all in one cycle.
        chk("t4_pre_valid", {31'b0, valid}, 32'd1);
        chk("t4_pre_ack", {31'b0, ack}, 32'd1);
        chk("t4_pre_stb", {31'b0, stb}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        chk("t4_valid", {31'b0, valid}, 32'd0);
        chk("t4_stb", {31'b0, stb}, 32'd0);
        chk("t4_adr", adr, 32'h400);
        exp_pc = 32'h400;
        run_until(32'h410, 30);

        // Stall for three cycles: address and strobe hold.
        chk("t5_stb0", {31'b0, stb}, 32'd1);
        hold_adr = adr;
        stall    = 1'b1;
        repeat (3) begin
            tick();
            chk("t5_adr", adr, hold_adr);
            chk("t5_stb", {31'b0, stb}, 32'd1);
        end
        stall  = 1'b0;
        target = exp_pc + 32'd32;
        run_until(target, 40);

        // Reset mid-burst, then a bus error at 0x108.
        err_addr = 32'h108;
        seen_err = 1'b0;
        do_reset(1'b1, 1'b1);
        repeat (15) tick();
        chk("t6_seen_err", {31'b0, seen_err}, 32'd1);
        chk("t6_last", exp_pc, 32'h110);
        chk("t6_stb", {31'b0, stb}, 32'd0);
        chk("t6_cyc", {31'b0, cyc}, 32'd0);
        chk("t6_valid", {31'b0, valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h3;
        tick();
        redirect = 1'b0;
        exp_pc   = 32'h0;
        chk("t6_stb1", {31'b0, stb}, 32'd1);
        chk("t6_adr1", adr, 32'h0);
        chk("t6_v1", {31'b0, valid}, 32'd0);
        tick();
        chk("t6_v2", {31'b0, valid}, 32'd0);
        tick();
        chk("t6_v3", {31'b0, valid}, 32'd1);
        run_until(32'h20, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
